// File: rtl/float_mul_arbiter_if.sv
// Bundle of requester, multiplier and response signals around float_mul_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface float_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic                  mul_clr;
  logic [31:0]           mul_z;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_z;
  logic [ID_W-1:0]       resp_id;

  modport slave (
    input  req_valid, req_a, req_b, mul_z, resp_ready,
    output req_ready, mul_a, mul_b, mul_clr, resp_valid, resp_z, resp_id
  );

  modport master (
    output req_valid, req_a, req_b, mul_z, resp_ready,
    input  req_ready, mul_a, mul_b, mul_clr, resp_valid, resp_z, resp_id
  );
endinterface

// File: rtl/float_mul_arbiter.sv
// Round-robin arbiter sharing one sequenced float multiplier among NUM_REQ requesters.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module float_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int MUL_LATENCY = 8,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  float_mul_arbiter_if.slave    bus,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mul_a_q, mul_a_d;
  logic [31:0]       mul_b_q, mul_b_d;
  logic              mul_clr_q, mul_clr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_z_q, resp_z_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] req_ready_d;
  int                pick;

  // Search starts just after the last winner so it has lowest priority next time.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pick      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pick = int'(last_q) + k;
      if (pick >= NUM_REQ) pick = pick - NUM_REQ;
      if (!win_found && bus.req_valid[pick]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(pick);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_clr_d    = mul_clr_q;
    resp_valid_d = resp_valid_q;
    resp_z_d     = resp_z_q;
    resp_id_d    = resp_id_q;
    req_ready_d  = '0;

    case (state_q)
      IDLE: begin
        mul_clr_d = 1'b1;
        if (win_found) begin
          req_ready_d[win_idx] = 1'b1;
          mul_a_d   = bus.req_a[32*int'(win_idx) +: 32];
          mul_b_d   = bus.req_b[32*int'(win_idx) +: 32];
          resp_id_d = win_idx;
          last_d    = win_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d     = '0;
        mul_clr_d = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        // Counter value k means the multiplier has been running k+1 cycles.
        if (cnt_q == CNT_W'(MUL_LATENCY-1)) begin
          resp_z_d     = bus.mul_z;
          resp_valid_d = 1'b1;
          mul_clr_d    = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_q       <= ID_W'(NUM_REQ-1);
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_clr_q    <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_z_q     <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_clr_q    <= mul_clr_d;
      resp_valid_q <= resp_valid_d;
      resp_z_q     <= resp_z_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.mul_clr    = mul_clr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_z     = resp_z_q;
  assign bus.resp_id    = resp_id_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Bench for float_mul_arbiter: directed scenarios plus random traffic against a
// transaction-level model (round-robin pick, expected-result queue, cycle-count timing).
module tb_float_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 8;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic [1:0] dbg_state;

  float_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus_if ();

  float_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LATENCY(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus variables ----------------
  logic [NUM_REQ-1:0] v = '0;
  logic [31:0] a_arr [NUM_REQ];
  logic [31:0] b_arr [NUM_REQ];
  logic        resp_rdy = 1'b1;

  always_comb begin
    bus_if.req_valid  = v;
    bus_if.resp_ready = resp_rdy;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus_if.req_a[32*i +: 32] = a_arr[i];
      bus_if.req_b[32*i +: 32] = b_arr[i];
    end
  end

  // ---------------- multiplier stand-in ----------------
  function automatic logic [31:0] mul_model(logic [31:0] a, logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'h7F800000 && b == 32'h00000000) return 32'hFFC00000;
    return {a[31] ^ b[31], a[30:0] ^ {b[15:0], b[30:16]}};
  endfunction

  int cnt_m = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_m <= 0;
    else if (bus_if.mul_clr) cnt_m <= 0;
    else if (cnt_m < 1000) cnt_m <= cnt_m + 1;
  end

  // Product is only meaningful LAT cycles after clear release; garbage before that.
  assign bus_if.mul_z = (!bus_if.mul_clr && cnt_m >= LAT-1) ?
                        mul_model(bus_if.mul_a, bus_if.mul_b) : 32'hBAD0BAD0;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] req);
    for (int k = 1; k <= NUM_REQ; k++)
      if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  logic [ID_W+31:0] exp_q[$];
  int          last_m    = NUM_REQ-1;
  int          grant_cyc = 0;
  logic [31:0] cur_a = '0, cur_b = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_z = '0;
  logic [ID_W-1:0] prev_id = '0;

  always @(negedge clk) begin
    int  w;
    int  d;
    logic exp_busy;
    logic exp_rv;
    if (!rst) begin
      last_m = NUM_REQ-1;
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      exp_busy = (exp_q.size() != 0);
      chk("busy", 32'(busy), 32'(exp_busy));
      if (!exp_busy) begin
        chk("mul_clr_idle", 32'(bus_if.mul_clr), 32'd1);
        chk("resp_valid_idle", 32'(bus_if.resp_valid), 32'd0);
        w = rr_pick(last_m, v);
        if (w < 0) begin
          chk("ready_none", 32'(bus_if.req_ready), 32'd0);
        end else begin
          chk("grant", 32'(bus_if.req_ready), 32'd1 << w);
          exp_q.push_back({ID_W'(w), mul_model(a_arr[w], b_arr[w])});
          cur_a = a_arr[w];
          cur_b = b_arr[w];
          last_m = w;
          grant_cyc = cyc;
        end
      end else begin
        d = cyc - grant_cyc;
        chk("ready_busy", 32'(bus_if.req_ready), 32'd0);
        chk("mul_a", bus_if.mul_a, cur_a);
        chk("mul_b", bus_if.mul_b, cur_b);
        // Grant edge, then ISSUE, then LAT cycles of WAIT before the result lands.
        chk("mul_clr", 32'(bus_if.mul_clr), 32'(!(d >= 2 && d <= LAT+1)));
        exp_rv = (d >= LAT+2);
        chk("resp_valid", 32'(bus_if.resp_valid), 32'(exp_rv));
        if (exp_rv && bus_if.resp_valid) begin
          chk("resp_id", 32'(bus_if.resp_id), 32'(exp_q[0][ID_W+31:32]));
          chk("resp_z", bus_if.resp_z, exp_q[0][31:0]);
          if (prev_hold) begin
            chk("hold_z", bus_if.resp_z, prev_z);
            chk("hold_id", 32'(bus_if.resp_id), 32'(prev_id));
          end
          if (resp_rdy) void'(exp_q.pop_front());
        end
      end
      prev_hold = bus_if.resp_valid && !resp_rdy;
      prev_z    = bus_if.resp_z;
      prev_id   = bus_if.resp_id;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic wait_grant(output int c, output int id);
    c = -1; id = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus_if.req_ready != '0) begin
        c = cyc;
        for (int i = 0; i < NUM_REQ; i++) if (bus_if.req_ready[i]) id = i;
        return;
      end
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(output int c);
    c = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus_if.resp_valid) begin
        c = cyc;
        return;
      end
    end
    chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus_if.resp_valid && !busy) return;
    end
    chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int gc, rc, id;
    int gcs [5];
    int ids [5];
    int exp_order [5];
    logic [31:0] z0;
    logic [ID_W-1:0] id0;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_mul_clr", 32'(bus_if.mul_clr), 32'd1);
    chk("rst_mul_a", bus_if.mul_a, 32'd0);
    chk("rst_mul_b", bus_if.mul_b, 32'd0);
    chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst_resp_z", bus_if.resp_z, 32'd0);
    chk("rst_resp_id", 32'(bus_if.resp_id), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Single request: 2.0 * 3.0
    @(posedge clk); #1;
    a_arr[0] = 32'h40000000; b_arr[0] = 32'h40400000; v = 4'b0001;
    wait_grant(gc, id);
    chk("single_grant", 32'(id), 32'd0);
    @(posedge clk); #1 v = '0;
    wait_resp(rc);
    chk("single_latency", 32'(rc - gc), 32'(LAT+2));
    chk("single_z", bus_if.resp_z, 32'h40C00000);
    chk("single_id", 32'(bus_if.resp_id), 32'd0);
    drain();

    // All four requesters, round-robin order and spacing
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = 32'h3F800000 + (i << 20);
      b_arr[i] = 32'h40000000 + (i << 16);
    end
    a_arr[1] = 32'h3FC00000; b_arr[1] = 32'h3FC00000;
    v = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(gcs[i], ids[i]);
      chk("rr_order", 32'(ids[i]), 32'(exp_order[i]));
      if (i > 0) chk("rr_spacing", 32'(gcs[i] - gcs[i-1]), 32'(LAT+3));
      if (i == 4) v = '0;
      @(posedge clk); #1;
    end
    v = '0;
    drain();

    // Backpressure: response must hold for 20 cycles
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    a_arr[0] = 32'h12345678; b_arr[0] = 32'h0F0F0F0F; v = 4'b0001;
    wait_grant(gc, id);
    @(posedge clk); #1 v = 4'b1111;
    wait_resp(rc);
    z0 = bus_if.resp_z; id0 = bus_if.resp_id;
    chk("bp_z", z0, mul_model(32'h12345678, 32'h0F0F0F0F));
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus_if.resp_valid), 32'd1);
      chk("bp_z_stable", bus_if.resp_z, z0);
      chk("bp_id_stable", 32'(bus_if.resp_id), 32'(id0));
      chk("bp_ready0", 32'(bus_if.req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 resp_rdy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_state", 32'(dbg_state), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 v = '0;
    drain();

    // Pointer wrap: 3 first, then 1, then 3
    do_reset();
    v = 4'b1000;
    wait_grant(gc, id);
    chk("wrap_first", 32'(id), 32'd3);
    @(posedge clk); #1 v = 4'b1010;
    wait_grant(gc, id);
    chk("wrap_second", 32'(id), 32'd1);
    @(posedge clk); #1;
    wait_grant(gc, id);
    chk("wrap_third", 32'(id), 32'd3);
    @(posedge clk); #1 v = '0;
    drain();

    // Reset while WAIT counter is 4
    @(posedge clk); #1 v = 4'b0010;
    wait_grant(gc, id);
    chk("abort_grant", 32'(id), 32'd1);
    v = 4'b1111;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_mul_clr", 32'(bus_if.mul_clr), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    wait_grant(gc, id);
    chk("abort_next_grant", 32'(id), 32'd0);
    @(posedge clk); #1 v = '0;
    drain();

    // Special value pass-through: +Inf * 0
    @(posedge clk); #1;
    a_arr[2] = 32'h7F800000; b_arr[2] = 32'h00000000; v = 4'b0100;
    wait_grant(gc, id);
    @(posedge clk); #1 v = '0;
    wait_resp(rc);
    chk("special_z", bus_if.resp_z, 32'hFFC00000);
    chk("special_id", 32'(bus_if.resp_id), 32'd2);
    drain();

    // Random traffic
    for (int t = 0; t < 800; t++) begin
      @(posedge clk); #1;
      resp_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          v[i] = ~v[i];
          a_arr[i] = $urandom;
          b_arr[i] = $urandom;
        end
      end
    end
    @(posedge clk); #1;
    v = '0;
    resp_rdy = 1'b1;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/float_mul_arbiter.md
Name: float_mul_arbiter

Overview:
- Shares one sequenced single-precision float multiplier among NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Holds the multiplier in clear, then releases it. It waits a fixed MUL_LATENCY cycles, captures the product and returns it with the requester id over a valid/ready response port.
- Sits between issuing units and the multiplier. It is the only driver of the multiplier's operand and clear inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width, clog2(NUM_REQ)
MUL_LATENCY, 8, cycles from multiplier clear release to a valid product at mul_z (>=2)
CNT_W, 4, width of the wait counter; must hold MUL_LATENCY-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  NUM_REQ  per-requester operation request
req_a  in  NUM_REQ*32  packed operand A, requester i at [32*i+31:32*i]
req_b  in  NUM_REQ*32  packed operand B, same packing
req_ready  out  NUM_REQ  one-hot grant/accept strobe (combinational)
mul_a  out  32  operand A to multiplier (registered)
mul_b  out  32  operand B to multiplier (registered)
mul_clr  out  1  active-high clear/restart of multiplier sequencer (registered)
mul_z  in  32  multiplier result
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_z  out  32  captured product
resp_id  out  ID_W  index of requester that issued the operation
busy  out  1  high in any state except IDLE

Behaviour:
- State register states: IDLE, ISSUE, WAIT, RESP.
- Reset (rst low, asynchronous) drives every register to its reset value:
  - state=IDLE, mul_a=0, mul_b=0, mul_clr=1, resp_valid=0, resp_z=0, resp_id=0, busy=0, wait counter=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation abandons the in-flight operation with no response. A requester already granted gets no result.
- IDLE:
  - mul_clr=1.
  - If any req_valid is high, the winner is the first set bit searching from last+1 upward, modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle; all other req_ready bits are 0. The handshake completes on this edge.
  - On the edge: mul_a/mul_b <= winner's operands, resp_id <= winner, last <= winner, go to ISSUE.
  - If no req_valid is high, stay in IDLE and keep req_ready=0.
- req_ready is 0 in every state except IDLE. A request whose req_valid drops before it is granted is simply not served.
- ISSUE:
  - One cycle; mul_clr=1 with operands already stable.
  - On the edge: wait counter <= 0, mul_clr <= 0, go to WAIT.
- WAIT:
  - mul_clr=0; the counter increments each cycle.
  - When the counter reaches MUL_LATENCY-1: resp_z <= mul_z, resp_valid <= 1, mul_clr <= 1, go to RESP.
- RESP:
  - resp_valid=1; resp_z and resp_id are held stable.
  - When resp_ready=1: resp_valid <= 0, go to IDLE.
  - With backpressure (resp_ready=0) the block stays in RESP indefinitely and grants no new request.
- Latency: resp_valid rises MUL_LATENCY+2 rising edges after the grant edge.
  - Minimum request-to-request period with resp_ready tied high is MUL_LATENCY+3 cycles.
- Fairness: a requester that has just been served has lowest priority in the next arbitration. With all requesters active, grants go 0,1,2,3,0,...
- A requester may hold req_valid continuously. It receives one grant per IDLE visit in which it wins.
- No arithmetic is done on the data. mul_z is captured bit-exact (NaN, Inf, zero and denormal results pass through unchanged).

Test Plan:
- Single request: rst released, req_valid=4'b0001, a=0x40000000 (2.0), b=0x40400000 (3.0) -> req_ready[0] pulses one cycle; resp_valid rises 10 edges later with resp_z=0x40C00000, resp_id=0.
- All four requesters valid with distinct operands, resp_ready=1 -> grants in order 0,1,2,3,0; each resp_id matches its operands' product (e.g. 0x3FC00000 x 0x3FC00000 -> 0x40100000); grant spacing is 11 cycles.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid -> resp_valid, resp_z and resp_id stay stable; req_ready stays 0; busy stays 1; IDLE is re-entered the cycle after resp_ready=1.
- Pointer wrap: only requesters 3 and 1 valid after a grant to 3 -> next grant is 1, then 3.
- Reset mid-WAIT: rst low for 1 cycle at counter=4 -> mul_clr=1, busy=0, resp_valid=0; no response for the aborted op; the next grant goes to requester 0 if valid.
- Special value: a=0x7F800000 (+Inf), b=0x00000000 -> resp_z equals the multiplier's NaN output 0xFFC00000, passed through unchanged.
